pipe_stage_reg: RTL and testbench

- Parametrised pipeline-stage register for the Y86 pipeline; replaces the per-stage D-register style.
- Sits between any two stages (F->D, D->E, E->M, M->W). Latches an instruction bundle each cycle.
- Supports stall, full-bundle bubble injection and status priority resolution.
- Adds valid tracking, an optional freeze-on-exception mode, and saturating stall/bubble performance counters.

---
 rtl/y86_pkg.sv | 23 ++
 rtl/pipe_stage_reg_if.sv | 47 ++++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 pipeline constants and the instruction bundle type.
package y86_pkg;

    localparam logic [3:0] STAT_AOK  = 4'd1;
    localparam logic [3:0] STAT_HLT  = 4'd2;
    localparam logic [3:0] STAT_ADR  = 4'd3;
    localparam logic [3:0] STAT_INS  = 4'd4;

    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    // Instruction bundle at the architectural widths (64-bit data, 4-bit stat).
    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
        logic [3:0]  stat;
    } y86_bundle_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-register bus: control, upstream bundle, registered bundle, status counters.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int STAT_W = 4,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              bubble;
    logic [3:0]        in_icode;
    logic [3:0]        in_ifun;
    logic [3:0]        in_rA;
    logic [3:0]        in_rB;
    logic [DATA_W-1:0] in_valC;
    logic [DATA_W-1:0] in_valP;
    logic [STAT_W-1:0] in_stat;
    logic              in_hlt;
    logic              in_imem_err;
    logic              in_instr_invalid;

    logic [3:0]        out_icode;
    logic [3:0]        out_ifun;
    logic [3:0]        out_rA;
    logic [3:0]        out_rB;
    logic [DATA_W-1:0] out_valC;
    logic [DATA_W-1:0] out_valP;
    logic [STAT_W-1:0] out_stat;
    logic              out_valid;
    logic              frozen;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    // Upstream / hazard-unit side.
    modport master (
        output stall, bubble, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP,
               in_stat, in_hlt, in_imem_err, in_instr_invalid,
        input  out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_stat,
               out_valid, frozen, stall_cnt, bubble_cnt
    );

    // Stage register side.
    modport slave (
        input  stall, bubble, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP,
               in_stat, in_hlt, in_imem_err, in_instr_invalid,
        output out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_stat,
               out_valid, frozen, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_d, cnt_q;

    // Next count: advance only when requested and not yet saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Y86 pipeline stage register: stall / bubble / load with status resolution,
// valid tracking, optional freeze on exception and stall/bubble counters.
module pipe_stage_reg
    import y86_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int STAT_W        = 4,
    parameter int CNT_W         = 16,
    parameter int FREEZE_ON_EXC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stage_reg_if.slave  bus
);
    typedef struct packed {
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        rA;
        logic [3:0]        rB;
        logic [DATA_W-1:0] valC;
        logic [DATA_W-1:0] valP;
        logic [STAT_W-1:0] stat;
    } bundle_t;

    localparam logic [STAT_W-1:0] S_AOK = STAT_W'(STAT_AOK);
    localparam logic [STAT_W-1:0] S_HLT = STAT_W'(STAT_HLT);
    localparam logic [STAT_W-1:0] S_ADR = STAT_W'(STAT_ADR);
    localparam logic [STAT_W-1:0] S_INS = STAT_W'(STAT_INS);

    // Reset and bubble contents are the same NOP bundle.
    localparam bundle_t NOP_BUNDLE = '{
        icode: ICODE_NOP, ifun: 4'h0, rA: REG_NONE, rB: REG_NONE,
        valC: '0, valP: '0, stat: S_AOK
    };

    bundle_t           bundle_d, bundle_q;
    logic              valid_d, valid_q;
    logic              frozen_d, frozen_q;
    logic              stall_inc, bubble_inc;
    logic [STAT_W-1:0] stat_res;

    // Upstream exception flags override the incoming stat: halt, then memory, then illegal.
    always_comb begin
        stat_res = bus.in_stat;
        if (bus.in_hlt)                stat_res = S_HLT;
        else if (bus.in_imem_err)      stat_res = S_ADR;
        else if (bus.in_instr_invalid) stat_res = S_INS;
    end

    // Next-state selection: frozen > stall > bubble > load; at most one counter bumps.
    always_comb begin
        bundle_d   = bundle_q;
        valid_d    = valid_q;
        frozen_d   = frozen_q;
        stall_inc  = 1'b0;
        bubble_inc = 1'b0;
        if (!frozen_q) begin
            if (bus.stall) begin
                stall_inc = 1'b1;
            end else if (bus.bubble) begin
                bundle_d   = NOP_BUNDLE;
                valid_d    = 1'b0;
                bubble_inc = 1'b1;
            end else begin
                bundle_d = '{
                    icode: bus.in_icode, ifun: bus.in_ifun, rA: bus.in_rA, rB: bus.in_rB,
                    valC: bus.in_valC, valP: bus.in_valP, stat: stat_res
                };
                valid_d = 1'b1;
                // Freeze only ever sets; leaving it requires reset.
                if ((FREEZE_ON_EXC != 0) && (stat_res != S_AOK))
                    frozen_d = 1'b1;
            end
        end
    end

    // Stage state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= NOP_BUNDLE;
            valid_q  <= 1'b0;
            frozen_q <= 1'b0;
        end else begin
            bundle_q <= bundle_d;
            valid_q  <= valid_d;
            frozen_q <= frozen_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .cnt   (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .cnt   (bus.bubble_cnt)
    );

    assign bus.out_icode = bundle_q.icode;
    assign bus.out_ifun  = bundle_q.ifun;
    assign bus.out_rA    = bundle_q.rA;
    assign bus.out_rB    = bundle_q.rB;
    assign bus.out_valC  = bundle_q.valC;
    assign bus.out_valP  = bundle_q.valP;
    assign bus.out_stat  = bundle_q.stat;
    assign bus.out_valid = valid_q;
    assign bus.frozen    = frozen_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (plain / freeze with 4-bit counters)
// compared against a rule-level reference model.
module tb_pipe_stage_reg;
    import y86_pkg::*;

    typedef struct packed {
        y86_bundle_t b;
        logic        valid;
        logic        frozen;
        logic [15:0] scnt;
        logic [15:0] bcnt;
    } model_t;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
        logic [3:0]  stat;
        logic        hlt;
        logic        imem;
        logic        inv;
    } in_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    in_t    cur;
    model_t ma, mb;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(64), .STAT_W(4), .CNT_W(16)) ifa ();
    pipe_stage_reg_if #(.DATA_W(64), .STAT_W(4), .CNT_W(4))  ifb ();

    pipe_stage_reg #(.DATA_W(64), .STAT_W(4), .CNT_W(16), .FREEZE_ON_EXC(0)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    pipe_stage_reg #(.DATA_W(64), .STAT_W(4), .CNT_W(4), .FREEZE_ON_EXC(1)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    function automatic model_t rst_model();
        model_t m;
        m.b      = '{icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF, valC: 64'h0, valP: 64'h0, stat: 4'd1};
        m.valid  = 1'b0;
        m.frozen = 1'b0;
        m.scnt   = 16'd0;
        m.bcnt   = 16'd0;
        return m;
    endfunction

    // One clock edge of the stage expressed as its rules.
    function automatic model_t step(model_t m, in_t i, bit fz_en, int cmax);
        model_t n = m;
        logic [3:0] st;
        if (m.frozen) return n;
        if (i.stall) begin
            if (int'(m.scnt) < cmax) n.scnt = m.scnt + 16'd1;
        end else if (i.bubble) begin
            n = rst_model();
            n.frozen = m.frozen;
            n.scnt   = m.scnt;
            n.bcnt   = (int'(m.bcnt) < cmax) ? m.bcnt + 16'd1 : m.bcnt;
        end else begin
            st = i.hlt ? 4'd2 : i.imem ? 4'd3 : i.inv ? 4'd4 : i.stat;
            n.b = '{icode: i.icode, ifun: i.ifun, rA: i.rA, rB: i.rB,
                    valC: i.valC, valP: i.valP, stat: st};
            n.valid = 1'b1;
            if (fz_en && st != 4'd1) n.frozen = 1'b1;
        end
        return n;
    endfunction

    function automatic model_t obs_a();
        model_t o;
        o.b = '{icode: ifa.out_icode, ifun: ifa.out_ifun, rA: ifa.out_rA, rB: ifa.out_rB,
                valC: ifa.out_valC, valP: ifa.out_valP, stat: ifa.out_stat};
        o.valid = ifa.out_valid; o.frozen = ifa.frozen;
        o.scnt = ifa.stall_cnt;  o.bcnt = ifa.bubble_cnt;
        return o;
    endfunction

    function automatic model_t obs_b();
        model_t o;
        o.b = '{icode: ifb.out_icode, ifun: ifb.out_ifun, rA: ifb.out_rA, rB: ifb.out_rB,
                valC: ifb.out_valC, valP: ifb.out_valP, stat: ifb.out_stat};
        o.valid = ifb.out_valid; o.frozen = ifb.frozen;
        o.scnt = {12'h0, ifb.stall_cnt}; o.bcnt = {12'h0, ifb.bubble_cnt};
        return o;
    endfunction

    function automatic in_t idle_in();
        in_t i = '0;
        i.stat = 4'd1;
        return i;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        i.stall  = ($urandom_range(0, 4) == 0);
        i.bubble = ($urandom_range(0, 3) == 0);
        i.icode  = 4'($urandom);
        i.ifun   = 4'($urandom);
        i.rA     = 4'($urandom);
        i.rB     = 4'($urandom);
        i.valC   = {$urandom, $urandom};
        i.valP   = {$urandom, $urandom};
        i.stat   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd1;
        i.hlt    = ($urandom_range(0, 11) == 0);
        i.imem   = ($urandom_range(0, 11) == 0);
        i.inv    = ($urandom_range(0, 11) == 0);
        return i;
    endfunction

    task automatic drive(input in_t i);
        cur = i;
        ifa.stall = i.stall; ifa.bubble = i.bubble; ifa.in_icode = i.icode; ifa.in_ifun = i.ifun;
        ifa.in_rA = i.rA; ifa.in_rB = i.rB; ifa.in_valC = i.valC; ifa.in_valP = i.valP;
        ifa.in_stat = i.stat; ifa.in_hlt = i.hlt; ifa.in_imem_err = i.imem; ifa.in_instr_invalid = i.inv;
        ifb.stall = i.stall; ifb.bubble = i.bubble; ifb.in_icode = i.icode; ifb.in_ifun = i.ifun;
        ifb.in_rA = i.rA; ifb.in_rB = i.rB; ifb.in_valC = i.valC; ifb.in_valP = i.valP;
        ifb.in_stat = i.stat; ifb.in_hlt = i.hlt; ifb.in_imem_err = i.imem; ifb.in_instr_invalid = i.inv;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            ma = step(ma, cur, 1'b0, 65535);
            mb = step(mb, cur, 1'b1, 15);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        ma = rst_model();
        mb = rst_model();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(rand_in());
        #2;
        rst_n = 1'b0;
        #1;
        ma = rst_model();
        mb = rst_model();
        checks++;
        if (ifa.out_icode !== 4'h1 || ifa.out_rA !== 4'hF || ifa.out_rB !== 4'hF ||
            ifa.out_stat !== 4'd1 || ifa.out_valid !== 1'b0 ||
            ifa.stall_cnt !== 16'd0 || ifa.bubble_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_a: got %h exp %h", obs_a(), ma);
        end
        checks++;
        if (obs_b() !== mb) begin
            errors++;
            $display("FAIL reset_b: got %h exp %h", obs_b(), mb);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_load_stat();
        in_t i = idle_in();
        i.icode = 4'd3; i.valC = 64'h1234; i.hlt = 1'b1; i.imem = 1'b1;
        drive(i);
        tick();
        checks++;
        if (ifa.out_icode !== 4'd3 || ifa.out_valC !== 64'h1234 ||
            ifa.out_stat !== 4'd2 || ifa.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_hlt: got %h exp icode=3 valC=1234 stat=2 valid=1", obs_a());
        end
        i = idle_in();
        i.icode = 4'd5; i.inv = 1'b1;
        drive(i);
        tick();
        checks++;
        if (ifa.out_stat !== 4'd4 || ifa.out_icode !== 4'd5) begin
            errors++;
            $display("FAIL load_ins: got stat=%0d icode=%0d exp stat=4 icode=5", ifa.out_stat, ifa.out_icode);
        end
        checks++;
        if (obs_b() !== mb) begin
            errors++;
            $display("FAIL load_b: got %h exp %h", obs_b(), mb);
        end
    endtask

    task automatic test_stall_over_bubble();
        in_t i;
        y86_bundle_t held;
        do_reset();
        i = rand_in();
        i.stall = 1'b0; i.bubble = 1'b0;
        drive(i);
        tick();
        held = obs_a().b;
        i.stall = 1'b1; i.bubble = 1'b1; i.icode = ~i.icode; i.valC = ~i.valC;
        drive(i);
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (obs_a().b !== held || ifa.stall_cnt !== 16'd3 || ifa.bubble_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stall_bubble: got %h scnt=%0d bcnt=%0d exp %h scnt=3 bcnt=0",
                     obs_a().b, ifa.stall_cnt, ifa.bubble_cnt, held);
        end
        checks++;
        if (obs_a() !== ma) begin
            errors++;
            $display("FAIL stall_model: got %h exp %h", obs_a(), ma);
        end
        rst_n = 1'b0;
        #1;
        ma = rst_model();
        mb = rst_model();
        checks++;
        if (obs_a() !== ma) begin
            errors++;
            $display("FAIL reset_mid_stall: got %h exp %h", obs_a(), ma);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_bubble();
        in_t i = idle_in();
        do_reset();
        i.icode = 4'd6; i.rA = 4'd2; i.ifun = 4'd5; i.valC = 64'hDEAD_BEEF; i.valP = 64'h40;
        drive(i);
        tick();
        i.bubble = 1'b1;
        drive(i);
        tick();
        checks++;
        if (ifa.out_icode !== 4'h1 || ifa.out_ifun !== 4'h0 || ifa.out_rA !== 4'hF ||
            ifa.out_rB !== 4'hF || ifa.out_valC !== 64'h0 || ifa.out_valP !== 64'h0 ||
            ifa.out_valid !== 1'b0 || ifa.out_stat !== 4'd1 || ifa.bubble_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bubble: got %h exp NOP bundle bcnt=1", obs_a());
        end
        drive(idle_in());
    endtask

    task automatic test_freeze();
        in_t i = idle_in();
        y86_bundle_t held;
        do_reset();
        i.icode = 4'd2; i.imem = 1'b1; i.valP = 64'h99;
        drive(i);
        tick();
        checks++;
        if (ifb.out_stat !== 4'd3 || ifb.frozen !== 1'b1 || ifb.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL freeze_set: got stat=%0d frozen=%0d exp stat=3 frozen=1", ifb.out_stat, ifb.frozen);
        end
        held = obs_b().b;
        for (int k = 0; k < 5; k++) begin
            i = rand_in();
            if (k == 3) i.stall = 1'b1;
            if (k == 4) begin i.stall = 1'b0; i.bubble = 1'b1; end
            drive(i);
            tick();
        end
        checks++;
        if (obs_b().b !== held || ifb.frozen !== 1'b1 || ifb.stall_cnt !== 4'd0 || ifb.bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL freeze_hold: got %h exp %h counters 0", obs_b(), held);
        end
        checks++;
        if (obs_a() !== ma) begin
            errors++;
            $display("FAIL freeze_a_model: got %h exp %h", obs_a(), ma);
        end
        rst_n = 1'b0;
        #1;
        ma = rst_model();
        mb = rst_model();
        checks++;
        if (ifb.frozen !== 1'b0 || obs_b() !== mb) begin
            errors++;
            $display("FAIL freeze_reset: got %h exp %h", obs_b(), mb);
        end
        rst_n = 1'b1;
        i = idle_in();
        i.icode = 4'd7;
        drive(i);
        tick();
        checks++;
        if (ifb.out_icode !== 4'd7 || ifb.out_valid !== 1'b1 || ifb.frozen !== 1'b0) begin
            errors++;
            $display("FAIL freeze_resume: got icode=%0d valid=%0d frozen=%0d exp 7 1 0",
                     ifb.out_icode, ifb.out_valid, ifb.frozen);
        end
    endtask

    task automatic test_saturation();
        in_t i = idle_in();
        do_reset();
        i.stall = 1'b1;
        drive(i);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15 || k == 16 || k == 20) begin
                checks++;
                if (ifb.stall_cnt !== 4'd15 || ifa.stall_cnt !== 16'(k)) begin
                    errors++;
                    $display("FAIL saturate_%0d: got b=%0d a=%0d exp b=15 a=%0d",
                             k, ifb.stall_cnt, ifa.stall_cnt, k);
                end
            end
        end
        drive(idle_in());
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive(rand_in());
                tick();
            end
            checks++;
            if (obs_a() !== ma || obs_b() !== mb) begin
                errors++;
                $display("FAIL random_%0d: a=%h exp %h b=%h exp %h", k, obs_a(), ma, obs_b(), mb);
            end
        end
    endtask

    initial begin
        ma = rst_model();
        mb = rst_model();
        test_reset();
        test_load_stat();
        test_stall_over_bubble();
        test_bubble();
        test_freeze();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
